// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the flexible FIFO
// Contents: FWFT_OFF/FWFT_ON read-mode selectors, fifo_depth() depth helper.
package fifo_pkg;

  localparam int FWFT_OFF = 0;  // registered read, data one cycle after rd
  localparam int FWFT_ON  = 1;  // first-word-fall-through

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage array, synchronous write, asynchronous read
// Ports: clk; we, w_addr, w_data (write port); r_addr -> r_data (async read).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  // Storage deliberately has no reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[w_addr] <= w_data;
    end
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised synchronous FIFO with FWFT option and status flags
// Ports: clk, reset (async, active-high), clr (sync flush); wr/w_data push,
//        rd pop, r_data read data; full/empty/almost_full/almost_empty/level
//        status; overflow/underflow sticky errors cleared by err_clr.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LVL_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF  = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_AE  = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rd_ok, wr_ok, wr_en;

  // Flags decode from the registered level only.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_MAX);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO still fits when a read leaves in the same cycle.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);
  assign wr_en = wr_ok & ~clr;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      level_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + PTR_ONE;
      if (rd_ok) r_ptr_d = r_ptr_q + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      // A new error in the same cycle overrides err_clr.
      if (wr & ~wr_ok) overflow_d  = 1'b1;
      if (rd & empty)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .w_addr (w_ptr_q),
    .w_data (w_data),
    .r_addr (r_ptr_q),
    .r_data (ram_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word shown directly; forced to zero while empty so the output
    // never shows stale or uninitialised storage.
    assign r_data = empty ? '0 : ram_rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_data_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data_q <= '0;
      end else if (clr) begin
        r_data_q <= '0;
      end else if (rd_ok) begin
        r_data_q <= ram_rdata;
      end
    end
    assign r_data = r_data_q;
  end

endmodule
